traffic_light_monitor: RTL and testbench

- Passive checker on the receiving end of the traffic-light output interface: samples green/yellow/red/walk/dontwalk every clock.
- Decodes the current phase and checks encoding legality, phase order and per-phase dwell time.
- Reports per-cycle error pulses, a sticky flag, a saturating error counter and a pulse per clean full cycle.
- Sits beside the light controller in the intersection subsystem; drives nothing back into it.

---
 rtl/traffic_light_monitor_if.sv | 36 +++
 rtl/traffic_light_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
// Traffic-light output bundle as seen by a passive monitor.
// The master side drives the lamp/walk signals and clr_err and observes the checker results.
// The slave side is the monitor itself.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    // Lamp and pedestrian signals, plus the error-clear request
    logic             green;
    logic             yellow;
    logic             red;
    logic             walk;
    logic             dontwalk;
    logic             clr_err;

    // Monitor results
    logic [1:0]       phase;
    logic             phase_valid;
    logic             err_encoding;
    logic             err_sequence;
    logic             err_dwell;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic             cycle_ok;

    modport master (
        output green, yellow, red, walk, dontwalk, clr_err,
        input  phase, phase_valid, err_encoding, err_sequence, err_dwell,
               err_sticky, err_count, cycle_ok
    );

    modport slave (
        input  green, yellow, red, walk, dontwalk, clr_err,
        output phase, phase_valid, err_encoding, err_sequence, err_dwell,
               err_sticky, err_count, cycle_ok
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive traffic-light checker.
// The lamp pattern is registered, then decoded and checked against the tracked phase.
// The checks cover encoding legality, phase order and per-phase dwell time.
// All results appear one cycle after the sample they describe.
module traffic_light_monitor #(
    parameter int GO_CYC   = 10,
    parameter int CAU_CYC  = 3,
    parameter int WALK_CYC = 7,
    parameter int CLR_CYC  = 2,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_light_monitor_if.slave   tl
);

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [1:0]       PH_GO    = 2'd0;
    localparam logic [1:0]       PH_CAU   = 2'd1;
    localparam logic [1:0]       PH_WALK  = 2'd2;
    localparam logic [1:0]       PH_CLR   = 2'd3;

    localparam logic [CNT_W-1:0] REQ_GO   = CNT_W'(GO_CYC);
    localparam logic [CNT_W-1:0] REQ_CAU  = CNT_W'(CAU_CYC);
    localparam logic [CNT_W-1:0] REQ_WALK = CNT_W'(WALK_CYC);
    localparam logic [CNT_W-1:0] REQ_CLR  = CNT_W'(CLR_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Input sample stage
    logic [4:0]       r_smp;
    logic             r_smp_vld;

    // Tracking state
    state_t           r_state;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_dwell;
    logic             r_armed;

    // Registered results
    logic             r_enc;
    logic             r_seq;
    logic             r_dwl;
    logic             r_ok;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    // Decode and check signals
    logic             w_legal;
    logic [1:0]       w_cur;
    logic [1:0]       w_next_ph;
    logic [CNT_W-1:0] w_req;
    logic [CNT_W-1:0] w_dwell_inc;
    logic             w_same;
    logic             w_track_chk;
    logic             w_enc;
    logic             w_seq;
    logic             w_dwl;
    logic             w_any;
    logic             w_ok;

    // Capture the lamp pattern.
    // Reset leaves an all-zero pattern, which is never flagged because r_smp_vld is clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp     <= '0;
            r_smp_vld <= 1'b0;
        end else begin
            r_smp     <= {tl.green, tl.yellow, tl.red, tl.walk, tl.dontwalk};
            r_smp_vld <= 1'b1;
        end
    end

    // Decode the sampled pattern into a phase and flag illegal combinations
    always_comb begin
        w_legal = 1'b1;
        w_cur   = PH_GO;
        case (r_smp)
            5'b10001: w_cur = PH_GO;
            5'b01001: w_cur = PH_CAU;
            5'b00110: w_cur = PH_WALK;
            5'b00101: w_cur = PH_CLR;
            default:  w_legal = 1'b0;
        endcase
    end

    // Look up the required dwell of the phase currently being tracked
    always_comb begin
        w_req = REQ_GO;
        case (r_phase)
            PH_GO:   w_req = REQ_GO;
            PH_CAU:  w_req = REQ_CAU;
            PH_WALK: w_req = REQ_WALK;
            PH_CLR:  w_req = REQ_CLR;
            default: w_req = REQ_GO;
        endcase
    end

    // Evaluate the checks for the sample held in r_smp
    always_comb begin
        w_next_ph   = r_phase + 2'd1;
        w_dwell_inc = (r_dwell == CNT_MAX) ? r_dwell : r_dwell + CNT_ONE;
        w_same      = (w_cur == r_phase);
        w_track_chk = r_smp_vld && w_legal && (r_state == TRACK);

        w_enc = r_smp_vld && !w_legal;
        w_seq = w_track_chk && !w_same && (w_cur != w_next_ph);
        // Overrun is flagged on the step where dwell would reach required+1.
        // Underrun is flagged on leaving the phase early.
        w_dwl = w_track_chk && (w_same ? (r_dwell == w_req) : (r_dwell < w_req));
        w_any = w_enc | w_seq | w_dwl;

        w_ok  = w_track_chk && r_armed && (r_phase == PH_CLR) && (w_cur == PH_GO) &&
                (r_dwell == REQ_CLR) && !w_any;
    end

    // Tracking FSM with registered result flags and error accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SYNC;
            r_phase  <= PH_GO;
            r_dwell  <= '0;
            r_armed  <= 1'b0;
            r_enc    <= 1'b0;
            r_seq    <= 1'b0;
            r_dwl    <= 1'b0;
            r_ok     <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_enc    <= w_enc;
            r_seq    <= w_seq;
            r_dwl    <= w_dwl;
            r_ok     <= w_ok;

            // The clear acts first, so an error in the same cycle survives it
            r_sticky <= w_any | (r_sticky & ~tl.clr_err);
            if (tl.clr_err) begin
                r_cnt <= w_any ? CNT_ONE : '0;
            end else if (w_any && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (r_smp_vld) begin
                if (!w_legal) begin
                    // The phase output keeps its last legal value.
                    // A zero dwell marks "no phase loaded" for SYNC.
                    r_state <= SYNC;
                    r_dwell <= '0;
                    r_armed <= 1'b0;
                end else begin
                    case (r_state)
                        SYNC: begin
                            if (r_dwell == '0) begin
                                r_phase <= w_cur;
                                r_dwell <= CNT_ONE;
                            end else if (w_same) begin
                                r_dwell <= w_dwell_inc;
                            end else begin
                                r_state <= TRACK;
                                r_phase <= w_cur;
                                r_dwell <= CNT_ONE;
                                r_armed <= (w_cur == PH_GO);
                            end
                        end
                        TRACK: begin
                            if (w_same) begin
                                r_dwell <= w_dwell_inc;
                                if (w_any) begin
                                    r_armed <= 1'b0;
                                end
                            end else begin
                                r_phase <= w_cur;
                                r_dwell <= CNT_ONE;
                                if (w_any) begin
                                    r_armed <= 1'b0;
                                end else if (w_cur == PH_GO) begin
                                    r_armed <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            r_state <= SYNC;
                            r_dwell <= '0;
                            r_armed <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign tl.phase        = r_phase;
    assign tl.phase_valid  = (r_state == TRACK);
    assign tl.err_encoding = r_enc;
    assign tl.err_sequence = r_seq;
    assign tl.err_dwell    = r_dwl;
    assign tl.err_sticky   = r_sticky;
    assign tl.err_count    = r_cnt;
    assign tl.cycle_ok     = r_ok;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor.
// A segment table drives runs of one lamp pattern.
// Each segment is checked for the pulse counts it causes and the state left at its end.
// Hand-written sequences cover cycle_ok spacing, saturation, clr_err and async reset.
module tb_traffic_light_monitor;

    localparam logic [4:0] P_GO   = 5'b10001;
    localparam logic [4:0] P_CAU  = 5'b01001;
    localparam logic [4:0] P_WALK = 5'b00110;
    localparam logic [4:0] P_CLR  = 5'b00101;
    localparam logic [4:0] P_BAD  = 5'b11001;

    typedef struct {
        logic [4:0] pat;
        int         len;
        int         n_enc;
        int         n_seq;
        int         n_dwl;
        int         n_ok;
        int         ph;
        int         vld;
        int         cnt;
        int         sticky;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CNT_W(8)) tl ();

    traffic_light_monitor #(
        .GO_CYC  (10),
        .CAU_CYC (3),
        .WALK_CYC(7),
        .CLR_CYC (2),
        .CNT_W   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tl (tl)
    );

    int   n_cmp = 0;
    int   n_mis = 0;
    seg_t tab[$];
    int   a_enc, a_seq, a_dwl, a_ok;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic [4:0] p, input logic c);
        {tl.green, tl.yellow, tl.red, tl.walk, tl.dontwalk} = p;
        tl.clr_err = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_seg(input logic [4:0] p, input int len, input int e, input int q,
                           input int d, input int ok, input int ph, input int vld,
                           input int cnt, input int st);
        seg_t s;
        s.pat = p; s.len = len; s.n_enc = e; s.n_seq = q; s.n_dwl = d; s.n_ok = ok;
        s.ph = ph; s.vld = vld; s.cnt = cnt; s.sticky = st;
        tab.push_back(s);
    endtask

    task automatic acc_clear();
        a_enc = 0; a_seq = 0; a_dwl = 0; a_ok = 0;
    endtask

    task automatic acc_add();
        a_enc += int'(tl.err_encoding);
        a_seq += int'(tl.err_sequence);
        a_dwl += int'(tl.err_dwell);
        a_ok  += int'(tl.cycle_ok);
    endtask

    task automatic check_seg(input int s);
        chk($sformatf("seg%0d n_enc", s),  a_enc, tab[s].n_enc);
        chk($sformatf("seg%0d n_seq", s),  a_seq, tab[s].n_seq);
        chk($sformatf("seg%0d n_dwell", s), a_dwl, tab[s].n_dwl);
        chk($sformatf("seg%0d n_ok", s),   a_ok,  tab[s].n_ok);
        chk($sformatf("seg%0d phase", s),  int'(tl.phase), tab[s].ph);
        chk($sformatf("seg%0d valid", s),  int'(tl.phase_valid), tab[s].vld);
        chk($sformatf("seg%0d count", s),  int'(tl.err_count), tab[s].cnt);
        chk($sformatf("seg%0d sticky", s), int'(tl.err_sticky), tab[s].sticky);
    endtask

    task automatic do_reset();
        drive('0, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst phase",  int'(tl.phase), 0);
        chk("rst valid",  int'(tl.phase_valid), 0);
        chk("rst errors", int'({tl.err_encoding, tl.err_sequence, tl.err_dwell}), 0);
        chk("rst sticky", int'(tl.err_sticky), 0);
        chk("rst count",  int'(tl.err_count), 0);
        chk("rst ok",     int'(tl.cycle_ok), 0);
        rst = 1'b1;
    endtask

    function automatic logic [4:0] nominal(input int i);
        int m;
        m = i % 22;
        if (m < 10)      return P_GO;
        else if (m < 13) return P_CAU;
        else if (m < 20) return P_WALK;
        else             return P_CLR;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ok, second_ok, n_ok, n_err;

        //       pat     len enc seq dwl ok ph vld cnt st
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 0, 0, 0);  // 0  SYNC
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 1, 0, 0);  // 1  enter TRACK
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 0, 0);
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 0, 0);
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 1, 0, 0);  // 4  arms only
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 1, 0, 0);
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 0, 0);
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 0, 0);
        add_seg(P_GO,   10, 0, 0, 0, 1, 0, 1, 0, 0);  // 8  first cycle_ok
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 1, 0, 0);
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 0, 0);
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 0, 0);
        add_seg(P_GO,   12, 0, 0, 1, 1, 0, 1, 1, 1);  // 12 ok, then overrun
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 1, 1, 1);
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 1, 1);
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 1, 1);
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 1, 1, 1);  // 16 no ok after error
        add_seg(P_CAU,   2, 0, 0, 0, 0, 1, 1, 1, 1);  // 17 short caution
        add_seg(P_WALK,  7, 0, 0, 1, 0, 2, 1, 2, 1);  // 18 underrun seen here
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 2, 1);
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 1, 2, 1);
        add_seg(P_WALK,  7, 0, 1, 0, 0, 2, 1, 3, 1);  // 21 skipped caution
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 3, 1);
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 1, 3, 1);
        add_seg(P_BAD,   3, 3, 0, 0, 0, 0, 0, 6, 1);  // 24 illegal pattern
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 0, 6, 1);  // 25 reload in SYNC
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 6, 1);  // 26 back in TRACK
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 6, 1);
        add_seg(P_GO,   10, 0, 0, 0, 0, 0, 1, 6, 1);  // 28 arms
        add_seg(P_CAU,   3, 0, 0, 0, 0, 1, 1, 6, 1);
        add_seg(P_WALK,  7, 0, 0, 0, 0, 2, 1, 6, 1);
        add_seg(P_CLR,   2, 0, 0, 0, 0, 3, 1, 6, 1);
        add_seg(P_GO,   10, 0, 0, 0, 1, 0, 1, 6, 1);  // 32 ok after resync

        drive('0, 1'b0);
        do_reset();
        acc_clear();

        // The result seen after each edge belongs to the sample driven one cycle earlier
        for (int s = 0; s < tab.size(); s++) begin
            for (int c = 0; c < tab[s].len; c++) begin
                drive(tab[s].pat, 1'b0);
                tick();
                if (s > 0 || c > 0) acc_add();
                if (s > 0 && c == 0) begin
                    check_seg(s - 1);
                    acc_clear();
                end
            end
        end
        drive(P_GO, 1'b0);
        tick();
        acc_add();
        check_seg(tab.size() - 1);

        // cycle_ok spacing on a clean stream: responses to samples 44 and 66
        do_reset();
        first_ok = -1; second_ok = -1; n_ok = 0; n_err = 0;
        for (int i = 0; i < 70; i++) begin
            drive(nominal(i), 1'b0);
            tick();
            n_err += int'(tl.err_encoding) + int'(tl.err_sequence) + int'(tl.err_dwell);
            if (tl.cycle_ok) begin
                n_ok++;
                if (first_ok < 0) first_ok = i + 1;
                else if (second_ok < 0) second_ok = i + 1;
            end
        end
        chk("nominal ok count", n_ok, 2);
        chk("nominal first ok edge", first_ok, 46);
        chk("nominal ok spacing", second_ok - first_ok, 22);
        chk("nominal error pulses", n_err, 0);
        chk("nominal err_count", int'(tl.err_count), 0);

        // Persistent illegal pattern: counting, saturation, clear with simultaneous error
        do_reset();
        a_enc = 0;
        for (int k = 0; k < 4; k++) begin
            drive(P_BAD, 1'b0);
            tick();
            a_enc += int'(tl.err_encoding);
        end
        chk("bad3 enc pulses", a_enc, 3);
        chk("bad3 err_count", int'(tl.err_count), 3);
        chk("bad3 valid", int'(tl.phase_valid), 0);
        for (int k = 0; k < 296; k++) begin
            drive(P_BAD, 1'b0);
            tick();
        end
        chk("sat err_count", int'(tl.err_count), 255);
        drive(P_BAD, 1'b1);
        tick();
        chk("clr+err count", int'(tl.err_count), 1);
        chk("clr+err sticky", int'(tl.err_sticky), 1);
        drive(P_BAD, 1'b0);
        tick();
        chk("after clr count", int'(tl.err_count), 2);

        // Resync on the next legal phase change
        drive(P_CAU, 1'b0);
        tick();
        drive(P_CAU, 1'b0);
        tick();
        chk("resync first phase", int'(tl.phase), 1);
        chk("resync first valid", int'(tl.phase_valid), 0);
        drive(P_WALK, 1'b0);
        tick();
        drive(P_WALK, 1'b0);
        tick();
        chk("resync track valid", int'(tl.phase_valid), 1);
        chk("resync track phase", int'(tl.phase), 2);
        chk("resync no enc", int'(tl.err_encoding), 0);
        chk("resync count", int'(tl.err_count), 3);

        // Reset between clock edges must clear state immediately
        #2;
        rst = 1'b0;
        #1;
        chk("async rst count", int'(tl.err_count), 0);
        chk("async rst sticky", int'(tl.err_sticky), 0);
        chk("async rst valid", int'(tl.phase_valid), 0);
        chk("async rst phase", int'(tl.phase), 0);
        tick();
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
